// File: rtl/disp_scan_mux.sv
// ---------------------------------------------------------------------------
// disp_scan_mux
//
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// It steps through the four BCD digits one slot at a time. For the selected
// digit it presents the nibble to the segment decoder and pulls the matching
// active-low anode low.
//
// Each slot starts with a short blank guard that holds all anodes off.
// This stops the previous digit's segments from ghosting onto the new one.
// Digits flagged in blink_mask go dark during the odd blink half-period.
// They keep their scan slot, so the other digits' timing and brightness
// do not change.
//
// Ports:
//   CLK         system clock, all state updates on the rising edge
//   RESET       synchronous, active-high reset
//   d0..d3      digit values, d0 rightmost, d3 leftmost
//   blink_mask  bit i set: digit i blinks
//   mux_digit   currently selected nibble, combinational from d[idx]
//   an          anode enables, active-low, bit i = digit i
//   digit_idx   index of the digit currently selected
//   frame_tick  registered one-cycle pulse in the first cycle of each frame
// ---------------------------------------------------------------------------
module disp_scan_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 4,
    parameter int BLINK_FRAMES = 128
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] blink_mask,
    output logic [3:0] mux_digit,
    output logic [3:0] an,
    output logic [1:0] digit_idx,
    output logic       frame_tick
);

    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              blink_phase_q, blink_phase_d;
    logic              frame_tick_q, frame_tick_d;
    logic              tick;
    logic              blank;

    // The slot ends on the last count of the slot counter. That same cycle
    // advances the digit index, and on digit 3 it also advances the frame.
    assign tick = (cnt_q == CNT_LAST);

    // With the guard disabled there is nothing to compare against.
    // Tying blank off here avoids a comparison that is always false.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_guard
            assign blank = 1'b0;
        end else begin : g_guard
            assign blank = (cnt_q < CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    // Next-state logic for the scan counters. frame_tick defaults low, so it
    // only rises for the single cycle after the slot-3 tick. The blink phase
    // flips once every BLINK_FRAMES complete frames.
    always_comb begin
        cnt_d         = cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        fcnt_d        = fcnt_q;
        blink_phase_d = blink_phase_q;
        frame_tick_d  = 1'b0;
        if (tick) begin
            cnt_d        = '0;
            idx_d        = idx_q + 2'd1;
            frame_tick_d = (idx_q == 2'd3);
            if (idx_q == 2'd3) begin
                if (fcnt_q == FCNT_LAST) begin
                    fcnt_d        = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                end
            end
        end
    end

    // State register. Reset wins over every other update, even mid-slot.
    // blink_phase resets to the visible phase.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            fcnt_q        <= '0;
            blink_phase_q <= 1'b0;
            frame_tick_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            fcnt_q        <= fcnt_d;
            blink_phase_q <= blink_phase_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    // Digit select is purely combinational, so live counter updates show up
    // in the same cycle. Values 10..15 pass straight through to the decoder.
    always_comb begin
        mux_digit = d0;
        case (idx_q)
            2'd0:    mux_digit = d0;
            2'd1:    mux_digit = d1;
            2'd2:    mux_digit = d2;
            default: mux_digit = d3;
        endcase
    end

    // Anode drive depends only on registered state and blink_mask. At most
    // the selected anode is pulled low, and only outside the guard window and
    // outside that digit's dark blink phase.
    always_comb begin
        an = 4'b1111;
        if (!blank && !(blink_phase_q && blink_mask[idx_q])) begin
            an[idx_q] = 1'b0;
        end
    end

    assign digit_idx  = idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_disp_scan_mux
//
// Self-checking bench for disp_scan_mux, built with REFRESH_DIV=4,
// BLANK_CYCLES=1 and BLINK_FRAMES=2. A second instance built with
// BLANK_CYCLES=0 shares the same inputs, so the no-guard anode pattern is
// checked alongside the main instance.
// ---------------------------------------------------------------------------
module tb_disp_scan_mux;

    localparam int RD = 4;
    localparam int BC = 1;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] d0 = 4'd0, d1 = 4'd0, d2 = 4'd0, d3 = 4'd0;
    logic [3:0] blinkMask = 4'd0;

    logic [3:0] muxDigit, an, muxDigitG, anG;
    logic [1:0] digitIdx, digitIdxG;
    logic       frameTick, frameTickG;

    typedef struct {
        string      name;
        logic [3:0] an;
        logic [3:0] mux;
        logic [1:0] idx;
        logic       ft;
        logic [3:0] anG;
    } expT;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [3:0] mux;
        logic [1:0] idx;
        logic       ft;
    } vecT;

    expT sbQueue[$];
    vecT scanTab[17];
    int  total = 0;
    int  bad = 0;
    int  lit[3];

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    disp_scan_mux #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
        .CLK(clk), .RESET(reset),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .blink_mask(blinkMask),
        .mux_digit(muxDigit), .an(an), .digit_idx(digitIdx), .frame_tick(frameTick)
    );

    disp_scan_mux #(.REFRESH_DIV(RD), .BLANK_CYCLES(0), .BLINK_FRAMES(BF)) dutG (
        .CLK(clk), .RESET(reset),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .blink_mask(blinkMask),
        .mux_digit(muxDigitG), .an(anG), .digit_idx(digitIdxG), .frame_tick(frameTickG)
    );

    // Single comparison with failure reporting
    task automatic checkVal(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected anode pattern from the cycle position within the slot and frame
    function automatic logic [3:0] anFor(input int cnt, input int id, input int phase,
                                         input logic [3:0] mask, input int blankCycles);
        logic [3:0] r;
        r = 4'b1111;
        if (cnt >= blankCycles && !(phase == 1 && mask[id] == 1'b1)) r[id] = 1'b0;
        return r;
    endfunction

    // Reference model: cycle k counts from the first cycle after reset
    function automatic expT modelExp(input string name, input int k,
                                     input logic [3:0] a0, input logic [3:0] a1,
                                     input logic [3:0] a2, input logic [3:0] a3,
                                     input logic [3:0] mask);
        expT e;
        int  cnt, id, phase;
        cnt   = k % RD;
        id    = (k / RD) % 4;
        phase = (k / (4 * RD * BF)) % 2;
        e.name = $sformatf("%s k=%0d", name, k);
        e.idx  = 2'(id);
        e.mux  = (id == 0) ? a0 : (id == 1) ? a1 : (id == 2) ? a2 : a3;
        e.an   = anFor(cnt, id, phase, mask, BC);
        e.anG  = anFor(cnt, id, phase, mask, 0);
        e.ft   = (k > 0 && (k % (4 * RD)) == 0);
        return e;
    endfunction

    // Drive inputs and push the matching expectation onto the scoreboard
    task automatic applyStimulus(input logic [3:0] a0, input logic [3:0] a1,
                                 input logic [3:0] a2, input logic [3:0] a3,
                                 input logic [3:0] mask, input expT e);
        d0 = a0; d1 = a1; d2 = a2; d3 = a3;
        blinkMask = mask;
        sbQueue.push_back(e);
    endtask

    // Pop the oldest expectation and compare against both instances
    task automatic checkOutput();
        expT e;
        if (sbQueue.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sbQueue.pop_front();
            checkVal({e.name, " an"}, int'(an), int'(e.an));
            checkVal({e.name, " mux"}, int'(muxDigit), int'(e.mux));
            checkVal({e.name, " idx"}, int'(digitIdx), int'(e.idx));
            checkVal({e.name, " ft"}, int'(frameTick), int'(e.ft));
            checkVal({e.name, " anG"}, int'(anG), int'(e.anG));
            if (blinkMask == 4'd0)
                checkVal({e.name, " anG onehot"}, $countones(~anG), 1);
        end
    endtask

    // One model-checked cycle using the currently held inputs
    task automatic modelCycle(input string name, input int k);
        if (k > 0) @(negedge clk);
        applyStimulus(d0, d1, d2, d3, blinkMask, modelExp(name, k, d0, d1, d2, d3, blinkMask));
        #1;
        checkOutput();
    endtask

    // Leaves the bench at cycle 0: one reset edge has passed
    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        expT e;

        // Scan order expectations with d0..d3 = 1,2,3,4 and no blinking
        scanTab[0]  = '{0,  4'b1111, 4'd1, 2'd0, 1'b0};
        scanTab[1]  = '{1,  4'b1110, 4'd1, 2'd0, 1'b0};
        scanTab[2]  = '{2,  4'b1110, 4'd1, 2'd0, 1'b0};
        scanTab[3]  = '{3,  4'b1110, 4'd1, 2'd0, 1'b0};
        scanTab[4]  = '{4,  4'b1111, 4'd2, 2'd1, 1'b0};
        scanTab[5]  = '{5,  4'b1101, 4'd2, 2'd1, 1'b0};
        scanTab[6]  = '{6,  4'b1101, 4'd2, 2'd1, 1'b0};
        scanTab[7]  = '{7,  4'b1101, 4'd2, 2'd1, 1'b0};
        scanTab[8]  = '{8,  4'b1111, 4'd3, 2'd2, 1'b0};
        scanTab[9]  = '{9,  4'b1011, 4'd3, 2'd2, 1'b0};
        scanTab[10] = '{10, 4'b1011, 4'd3, 2'd2, 1'b0};
        scanTab[11] = '{11, 4'b1011, 4'd3, 2'd2, 1'b0};
        scanTab[12] = '{12, 4'b1111, 4'd4, 2'd3, 1'b0};
        scanTab[13] = '{13, 4'b0111, 4'd4, 2'd3, 1'b0};
        scanTab[14] = '{14, 4'b0111, 4'd4, 2'd3, 1'b0};
        scanTab[15] = '{15, 4'b0111, 4'd4, 2'd3, 1'b0};
        scanTab[16] = '{16, 4'b1111, 4'd1, 2'd0, 1'b1};

        $display("[TB] scan order and frame tick");
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4; blinkMask = 4'd0;
        doReset();
        for (int i = 0; i < 17; i++) begin
            if (i > 0) @(negedge clk);
            e.name = $sformatf("scan k=%0d", scanTab[i].cyc);
            e.an   = scanTab[i].an;
            e.mux  = scanTab[i].mux;
            e.idx  = scanTab[i].idx;
            e.ft   = scanTab[i].ft;
            e.anG  = 4'b1111 ^ (4'b0001 << scanTab[i].idx);
            applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'd0, e);
            #1;
            checkOutput();
        end
        for (int k = 17; k < 64; k++) modelCycle("ftick", k);

        $display("[TB] blink digit 0");
        blinkMask = 4'b0001;
        lit = '{0, 0, 0};
        doReset();
        for (int k = 0; k < 96; k++) begin
            modelCycle("blink", k);
            if (an == 4'b1110) lit[k / 32]++;
        end
        checkVal("blink lit frames 0-1", lit[0], 6);
        checkVal("blink lit frames 2-3", lit[1], 0);
        checkVal("blink lit frames 4-5", lit[2], 6);

        $display("[TB] reset mid-scan during dark blink phase");
        doReset();
        for (int k = 0; k <= 42; k++) modelCycle("premid", k);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) modelCycle("postmid", k);

        $display("[TB] live data and pass-through");
        blinkMask = 4'd0;
        d0 = 4'd5; d1 = 4'd12; d2 = 4'd15; d3 = 4'd10;
        doReset();
        for (int k = 0; k <= 2; k++) modelCycle("live", k);
        e.name = "live d0 change";
        e.an   = 4'b1110;
        e.mux  = 4'd9;
        e.idx  = 2'd0;
        e.ft   = 1'b0;
        e.anG  = 4'b1110;
        applyStimulus(4'd9, d1, d2, d3, 4'd0, e);
        #1;
        checkOutput();
        for (int k = 3; k < 16; k++) modelCycle("passthru", k);

        checkVal("scoreboard drained", sbQueue.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
